// File: rtl/i2s_pkg.sv
// i2s_pkg
//   Shared types and sizing helpers for the I2S transmit path.
//   DATA_BIT is the sample width shared with the receive path. It is normally
//   defined by i2s_map.svh. The guard keeps a standalone build of this slice
//   consistent with that value.
//   Contents:
//     stereo_t    packed left/right sample pair, left in the upper half
//     CountW      width of the shared bit counter index
//     levelWidth  occupancy width for a FIFO of a given depth (one extra bit)

`ifndef DATA_BIT
`define DATA_BIT 24
`endif

package i2s_pkg;

  localparam int DataBit = `DATA_BIT;
  localparam int CountW  = $clog2(`DATA_BIT);

  typedef struct packed {
    logic [`DATA_BIT-1:0] l;
    logic [`DATA_BIT-1:0] r;
  } stereo_t;

  // An occupancy counter needs one bit more than the pointers, so that it can
  // tell "full" apart from "empty".
  function automatic int levelWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo
//   Synchronous FIFO of stereo pairs with show-ahead output.
//   The head entry is always visible on dout, so a consumer can take it in the
//   same cycle that it pops.
//   Ports:
//     clk, reset_n  clock and asynchronous active-low reset
//     push, din     write request and data. Ignored while full.
//     pop           read request. Ignored while empty.
//     dout          current head entry. Only meaningful while not empty.
//     level         occupancy in pairs
//     full, empty   occupancy flags, derived from registered state

module i2s_tx_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push,
  input  stereo_t                       din,
  input  logic                          pop,
  output stereo_t                       dout,
  output logic [levelWidth(DEPTH)-1:0]  level,
  output logic                          full,
  output logic                          empty
);

  localparam int PtrW   = $clog2(DEPTH);
  localparam int LevelW = levelWidth(DEPTH);
  localparam logic [LevelW-1:0] LevelFull = LevelW'(DEPTH);

  stereo_t             mem [DEPTH];
  logic [PtrW-1:0]     wrPtr_q;
  logic [PtrW-1:0]     rdPtr_q;
  logic [LevelW-1:0]   level_q;
  logic                doPush;
  logic                doPop;

  assign full   = (level_q == LevelFull);
  assign empty  = (level_q == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign dout   = mem[rdPtr_q];
  assign level  = level_q;

  // The storage array is not reset. Stale entries are never observed,
  // because empty gates every read.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr_q] <= din;
    end
  end

  // The pointers wrap naturally because DEPTH is a power of two.
  // A simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PtrW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PtrW'(1);
      case ({doPush, doPop})
        2'b10:   level_q <= level_q + LevelW'(1);
        2'b01:   level_q <= level_q - LevelW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx
//   I2S serial-data transmitter.
//   Source pairs are queued in a small FIFO. At each frame boundary one pair
//   is latched into the frame registers. That pair is then shifted out MSB
//   first, on SCLK falling-edge strobes, at the bit index given by the shared
//   I2S counter.
//   Ports:
//     i_clk_12_288, i_reset_n   system clock and asynchronous active-low reset
//     i_frame                   frame-boundary pulse (loads the next pair)
//     i_sclk_fall               SCLK falling-edge strobe (o_sd updates only here)
//     i_count, i_count_valid,   bit index, data-slot qualifier and channel
//       i_count_lrclk             select from the shared counter
//     i_audio_l/r, i_valid,     source pair handshake
//       o_ready
//     o_sd                      serial data
//     o_underrun                one-cycle pulse after a frame found the FIFO empty
//     o_level                   FIFO occupancy in pairs

module i2s_tx
  import i2s_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int UNDERRUN_HOLD = 0
) (
  input  logic                               i_clk_12_288,
  input  logic                               i_reset_n,
  input  logic                               i_frame,
  input  logic                               i_sclk_fall,
  input  logic [CountW-1:0]                  i_count,
  input  logic                               i_count_valid,
  input  logic                               i_count_lrclk,
  input  logic [DataBit-1:0]                 i_audio_l,
  input  logic [DataBit-1:0]                 i_audio_r,
  input  logic                               i_valid,
  output logic                               o_ready,
  output logic                               o_sd,
  output logic                               o_underrun,
  output logic [levelWidth(FIFO_DEPTH)-1:0]  o_level
);

  localparam logic [CountW:0] BitLimit = (CountW+1)'(DataBit);

  stereo_t fifoHead;
  stereo_t fifoDin;
  logic    fifoFull;
  logic    fifoEmpty;
  logic    fifoPush;
  logic    fifoPop;

  stereo_t frame_q, frame_d;
  stereo_t lastPair_q;
  logic    underrun_q;
  logic    sd_q, sd_d;

  assign fifoDin  = '{l: i_audio_l, r: i_audio_r};
  assign o_ready  = ~fifoFull;
  assign fifoPush = i_valid & o_ready;
  assign fifoPop  = i_frame & ~fifoEmpty;

  i2s_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (i_clk_12_288),
    .reset_n(i_reset_n),
    .push   (fifoPush),
    .din    (fifoDin),
    .pop    (fifoPop),
    .dout   (fifoHead),
    .level  (o_level),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  // On a frame boundary, take the FIFO head if there is one. Otherwise play
  // silence, or repeat the previous pair when UNDERRUN_HOLD is set. A push in
  // the same cycle is not yet in the FIFO, so it cannot rescue this frame.
  always_comb begin
    frame_d = frame_q;
    if (i_frame) begin
      if (!fifoEmpty) begin
        frame_d = fifoHead;
      end else if (UNDERRUN_HOLD != 0) begin
        frame_d = lastPair_q;
      end else begin
        frame_d = '0;
      end
    end
  end

  // The serializer reads frame_d rather than frame_q. A strobe that coincides
  // with a frame load therefore already sees the new pair.
  // Padding slots and out-of-range indices drive 0.
  always_comb begin
    sd_d = sd_q;
    if (i_sclk_fall) begin
      sd_d = 1'b0;
      if (i_count_valid && ({1'b0, i_count} < BitLimit)) begin
        sd_d = i_count_lrclk ? frame_d.r[i_count] : frame_d.l[i_count];
      end
    end
  end

  // Frame registers, last-played pair, underrun pulse and serial output flop.
  always_ff @(posedge i_clk_12_288 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      frame_q    <= '0;
      lastPair_q <= '0;
      underrun_q <= 1'b0;
      sd_q       <= 1'b0;
    end else begin
      frame_q    <= frame_d;
      underrun_q <= i_frame & fifoEmpty;
      sd_q       <= sd_d;
      if (fifoPop) begin
        lastPair_q <= fifoHead;
      end
    end
  end

  assign o_sd       = sd_q;
  assign o_underrun = underrun_q;

  // A valid slot must address a real sample bit. The shared counter never
  // produces anything else.
  assert property (@(posedge i_clk_12_288) disable iff (!i_reset_n)
    (i_sclk_fall && i_count_valid) |-> ({1'b0, i_count} < BitLimit));

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx
//   Directed bench for i2s_tx with DATA_BIT=24 and FIFO_DEPTH=4.
//   dut0 sends zeros on underrun. dut1 repeats the last pair on underrun.
//   A counter model generates 256-cycle frames: SCLK is clock/4, giving 64
//   slots per frame. Slot 0 of each half-frame is the I2S one-bit delay.
//   Slots 1..24 carry bits 23..0. The rest is padding.

module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int FrameCycles = 256;

  typedef struct {
    logic        valid;
    logic        frame;
    logic [23:0] l;
    logic [23:0] r;
    logic [2:0]  level;
    logic        ready;
    logic        underrun;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        genFrame = 1'b0;
  logic        manFrame = 1'b0;
  logic        frameSig;
  logic        sclkFall = 1'b0;
  logic        countValid = 1'b0;
  logic        countLr = 1'b0;
  logic [4:0]  count = '0;
  logic        valid0 = 1'b0;
  logic        valid1 = 1'b0;
  logic [23:0] l0 = '0, r0 = '0, l1 = '0, r1 = '0;
  logic        ready0, sd0, un0, ready1, sd1, un1;
  logic [2:0]  level0, level1;

  int          cyc = 0;
  int          framesLeft = 0;
  bit          counterRun = 1'b0;
  bit          frameOpen = 1'b0;
  logic        lastFall = 1'b0, lastValid = 1'b0, lastLr = 1'b0;
  logic [4:0]  lastCount = '0;
  logic [23:0] capL0 = '0, capR0 = '0, capL1 = '0, capR1 = '0;
  logic [47:0] log0[$];
  logic [47:0] log1[$];
  int          unCnt0 = 0, unCnt1 = 0;
  int          checks = 0, failures = 0;
  vec_t        vecs[16];

  assign frameSig = genFrame | manFrame;

  always #40 clk = ~clk;

  i2s_tx #(.FIFO_DEPTH(4), .UNDERRUN_HOLD(0)) dut0 (
    .i_clk_12_288(clk), .i_reset_n(resetN), .i_frame(frameSig),
    .i_sclk_fall(sclkFall), .i_count(count), .i_count_valid(countValid),
    .i_count_lrclk(countLr), .i_audio_l(l0), .i_audio_r(r0), .i_valid(valid0),
    .o_ready(ready0), .o_sd(sd0), .o_underrun(un0), .o_level(level0)
  );

  i2s_tx #(.FIFO_DEPTH(4), .UNDERRUN_HOLD(1)) dut1 (
    .i_clk_12_288(clk), .i_reset_n(resetN), .i_frame(frameSig),
    .i_sclk_fall(sclkFall), .i_count(count), .i_count_valid(countValid),
    .i_count_lrclk(countLr), .i_audio_l(l1), .i_audio_r(r1), .i_valid(valid1),
    .o_ready(ready1), .o_sd(sd1), .o_underrun(un1), .o_level(level1)
  );

  function automatic vec_t mkVec(logic v, logic f, logic [23:0] l, logic [23:0] r,
                                 logic [2:0] lv, logic rd, logic un);
    vec_t x;
    x.valid = v; x.frame = f; x.l = l; x.r = r;
    x.level = lv; x.ready = rd; x.underrun = un;
    return x;
  endfunction

  // One clock cycle: observe what the last posedge produced, then drive the
  // counter model for the next posedge.
  task automatic step();
    int slot;
    int sub;
    @(negedge clk);
    if (un0 === 1'b1) unCnt0++;
    if (un1 === 1'b1) unCnt1++;
    if (lastFall && lastValid) begin
      if (lastLr) begin
        capR0[lastCount] = sd0;
        capR1[lastCount] = sd1;
      end else begin
        capL0[lastCount] = sd0;
        capL1[lastCount] = sd1;
      end
    end
    if (counterRun && cyc == 0 && frameOpen) begin
      log0.push_back({capL0, capR0});
      log1.push_back({capL1, capR1});
      capL0 = '0; capR0 = '0; capL1 = '0; capR1 = '0;
      framesLeft--;
      if (framesLeft <= 0) begin
        counterRun = 1'b0;
        frameOpen  = 1'b0;
      end
    end
    if (counterRun) begin
      slot       = cyc / 4;
      sub        = slot % 32;
      sclkFall   = (cyc % 4 == 0);
      genFrame   = (cyc == 0);
      countLr    = (slot >= 32);
      countValid = (sub >= 1 && sub <= 24);
      count      = countValid ? 5'(24 - sub) : 5'd0;
      frameOpen  = 1'b1;
      cyc        = (cyc + 1) % FrameCycles;
    end else begin
      sclkFall = 1'b0; genFrame = 1'b0; countLr = 1'b0;
      countValid = 1'b0; count = '0;
    end
    lastFall = sclkFall; lastValid = countValid; lastCount = count; lastLr = countLr;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    valid0   = v.valid;
    l0       = v.l;
    r0       = v.r;
    manFrame = v.frame;
  endtask

  task automatic doReset();
    resetN = 1'b0;
    counterRun = 1'b0;
    frameOpen = 1'b0;
    step();
    step();
    resetN = 1'b1;
    log0.delete(); log1.delete();
    unCnt0 = 0; unCnt1 = 0;
  endtask

  task automatic startFrames(input int n);
    cyc = 0;
    framesLeft = n;
    frameOpen = 1'b0;
    capL0 = '0; capR0 = '0; capL1 = '0; capR1 = '0;
    counterRun = 1'b1;
  endtask

  task automatic runUntilStopped();
    for (int n = 0; n < FrameCycles * 8 && counterRun; n++) step();
    checkOutput("run_done", 64'(counterRun), 64'(0));
  endtask

  initial begin
    logic [23:0] pl[4];
    logic [23:0] pr[4];

    vecs[0]  = mkVec(1, 0, 24'h111111, 24'hAAAAAA, 3'd1, 1, 0);
    vecs[1]  = mkVec(1, 0, 24'h222222, 24'hBBBBBB, 3'd2, 1, 0);
    vecs[2]  = mkVec(1, 0, 24'h333333, 24'hCCCCCC, 3'd3, 1, 0);
    vecs[3]  = mkVec(1, 0, 24'h444444, 24'hDDDDDD, 3'd4, 0, 0);
    vecs[4]  = mkVec(1, 0, 24'h555555, 24'hEEEEEE, 3'd4, 0, 0);
    vecs[5]  = mkVec(1, 1, 24'h555555, 24'hEEEEEE, 3'd3, 1, 0);
    vecs[6]  = mkVec(1, 0, 24'h555555, 24'hEEEEEE, 3'd4, 0, 0);
    vecs[7]  = mkVec(0, 1, 24'h000000, 24'h000000, 3'd3, 1, 0);
    vecs[8]  = mkVec(0, 1, 24'h000000, 24'h000000, 3'd2, 1, 0);
    vecs[9]  = mkVec(0, 1, 24'h000000, 24'h000000, 3'd1, 1, 0);
    vecs[10] = mkVec(0, 1, 24'h000000, 24'h000000, 3'd0, 1, 0);
    vecs[11] = mkVec(0, 1, 24'h000000, 24'h000000, 3'd0, 1, 1);
    vecs[12] = mkVec(1, 1, 24'h666666, 24'h999999, 3'd1, 1, 1);
    vecs[13] = mkVec(0, 0, 24'h000000, 24'h000000, 3'd1, 1, 0);
    vecs[14] = mkVec(1, 1, 24'h777777, 24'h888888, 3'd1, 1, 0);
    vecs[15] = mkVec(0, 0, 24'h000000, 24'h000000, 3'd1, 1, 0);

    pl[0] = 24'hC00001; pr[0] = 24'h0F0F0F;
    pl[1] = 24'h5A5A5A; pr[1] = 24'hFFFFFE;
    pl[2] = 24'h000080; pr[2] = 24'h800000;
    pl[3] = 24'hDEADBE; pr[3] = 24'h012345;

    // Reset values
    step();
    step();
    checkOutput("reset_level0", 64'(level0), 64'(0));
    checkOutput("reset_ready0", 64'(ready0), 64'(1));
    checkOutput("reset_sd0",    64'(sd0),    64'(0));
    checkOutput("reset_un0",    64'(un0),    64'(0));
    checkOutput("reset_level1", 64'(level1), 64'(0));
    checkOutput("reset_ready1", 64'(ready1), 64'(1));
    resetN = 1'b1;
    step();

    // FIFO handshake and occupancy vectors, counter stopped
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d_level", i),    64'(level0), 64'(vecs[i].level));
      checkOutput($sformatf("vec%0d_ready", i),    64'(ready0), 64'(vecs[i].ready));
      checkOutput($sformatf("vec%0d_underrun", i), 64'(un0),    64'(vecs[i].underrun));
    end
    valid0 = 1'b0;
    manFrame = 1'b0;

    // Single pair, then one starved frame
    doReset();
    valid0 = 1'b1; l0 = 24'hA5F00F; r0 = 24'h123456;
    step();
    valid0 = 1'b0;
    startFrames(2);
    runUntilStopped();
    checkOutput("t1_frames", 64'(log0.size()), 64'(2));
    checkOutput("t1_frame1", 64'(log0[0]), {16'h0, 24'hA5F00F, 24'h123456});
    checkOutput("t1_frame2", 64'(log0[1]), 64'(0));
    checkOutput("t1_underruns", 64'(unCnt0), 64'(1));

    // Fill the FIFO, reject a fifth pair, replay in order
    doReset();
    for (int k = 0; k < 4; k++) begin
      valid0 = 1'b1; l0 = pl[k]; r0 = pr[k];
      step();
    end
    l0 = 24'hBADBAD; r0 = 24'hBADBAD;
    step();
    valid0 = 1'b0;
    checkOutput("t2_level_full", 64'(level0), 64'(4));
    checkOutput("t2_ready_full", 64'(ready0), 64'(0));
    startFrames(4);
    runUntilStopped();
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t2_frame%0d", k), 64'(log0[k]), {16'h0, pl[k], pr[k]});
    end
    checkOutput("t2_level_end", 64'(level0), 64'(0));
    checkOutput("t2_underruns", 64'(unCnt0), 64'(0));

    // Push in the same cycle as a frame that finds the FIFO empty
    doReset();
    startFrames(2);
    step();
    valid0 = 1'b1; l0 = 24'h3C3C3C; r0 = 24'hC3C3C3;
    step();
    valid0 = 1'b0;
    checkOutput("t4_underrun_pulse", 64'(un0), 64'(1));
    checkOutput("t4_level", 64'(level0), 64'(1));
    runUntilStopped();
    checkOutput("t4_frame1", 64'(log0[0]), 64'(0));
    checkOutput("t4_frame2", 64'(log0[1]), {16'h0, 24'h3C3C3C, 24'hC3C3C3});
    checkOutput("t4_underruns", 64'(unCnt0), 64'(1));

    // Repeat-last-pair underrun mode
    doReset();
    valid1 = 1'b1; l1 = 24'h800001; r1 = 24'h7FFFFE;
    step();
    valid1 = 1'b0;
    startFrames(4);
    runUntilStopped();
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t5_frame%0d", k), 64'(log1[k]), {16'h0, 24'h800001, 24'h7FFFFE});
    end
    checkOutput("t5_underruns", 64'(unCnt1), 64'(3));

    // Asynchronous reset in the middle of the right channel
    doReset();
    for (int k = 0; k < 3; k++) begin
      valid0 = 1'b1; l0 = 24'h0F0F0F; r0 = 24'hFFFFFF;
      step();
    end
    valid0 = 1'b0;
    startFrames(3);
    for (int n = 0; n < FrameCycles && cyc != 170; n++) step();
    checkOutput("t6_sd_before", 64'(sd0), 64'(1));
    #2 resetN = 1'b0;
    #1;
    checkOutput("t6_sd_reset",    64'(sd0),    64'(0));
    checkOutput("t6_level_reset", 64'(level0), 64'(0));
    checkOutput("t6_ready_reset", 64'(ready0), 64'(1));
    step();
    step();
    resetN = 1'b1;
    unCnt0 = 0;
    framesLeft = 2;
    runUntilStopped();
    checkOutput("t6_frames", 64'(log0.size()), 64'(2));
    checkOutput("t6_after_frame", 64'(log0[1]), 64'(0));
    checkOutput("t6_underruns", 64'(unCnt0), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
